// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronises IRQ_NUM lines, arbitrates lowest ID, AXI4-Lite claim/complete.
// Latency: level irq to trap_valid_o 3 cycles, edge irq 4 cycles; read/write responses 1 cycle after handshake.
// Backpressure: one outstanding AXI read and write; bvalid/rvalid held until bready/rready. EIRQ_EDGE_EN adds edge mode.
module ext_irq_ctrl #(
    parameter int IRQ_NUM = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IRQ_NUM-1:0] irq_i,
    output logic               trap_valid_o,
    input  logic               trap_ready_i,
    input  logic [31:0]        axi_awaddr,
    input  logic               axi_awvalid,
    output logic               axi_awready,
    input  logic [31:0]        axi_wdata,
    input  logic [3:0]         axi_wstrb,
    input  logic               axi_wvalid,
    output logic               axi_wready,
    output logic [1:0]         axi_bresp,
    output logic               axi_bvalid,
    input  logic               axi_bready,
    input  logic [31:0]        axi_araddr,
    input  logic               axi_arvalid,
    output logic               axi_arready,
    output logic [31:0]        axi_rdata,
    output logic [1:0]         axi_rresp,
    output logic               axi_rvalid,
    input  logic               axi_rready
);
    localparam int W = IRQ_NUM;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

    state_t       state_q;
    logic         trap_valid_q;
    logic [W-1:0] sync1_q, irq_s_q;
    logic [W-1:0] enable_q, enable_d;
    logic [W-1:0] pend_q, pending;
    logic [4:0]   claimed_id_q, claimed_id_d;
    logic         aw_rdy_q, aw_rdy_d;
    logic         bvalid_q, bvalid_d;
    logic         arready_q, arready_d;
    logic         rvalid_q, rvalid_d;
    logic [31:0]  rdata_q, rdata_d;

    logic         wr_hs, ar_hs, claim_hit, complete;
    logic [1:0]   wr_addr;
    logic [31:0]  wmask32, rd_val, mode_rd;
    logic [W-1:0] wmask, wdata_w, active, fsm_active;
    logic [4:0]   sel_id;

    assign wr_hs    = aw_rdy_q & axi_awvalid & axi_wvalid;
    assign ar_hs    = arready_q & axi_arvalid;
    assign wr_addr  = axi_awaddr[3:2];
    assign wmask32  = {{8{axi_wstrb[3]}}, {8{axi_wstrb[2]}}, {8{axi_wstrb[1]}}, {8{axi_wstrb[0]}}};
    assign wmask    = wmask32[W-1:0];
    assign wdata_w  = axi_wdata[W-1:0];

    // Claim selection uses live pending; the FSM uses the registered copy.
    assign active     = pending & enable_q;
    assign fsm_active = pend_q & enable_q;

    always_comb begin
        sel_id = 5'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (active[i]) sel_id = 5'(i + 1);
        end
    end

    assign claim_hit = ar_hs && (axi_araddr[3:2] == 2'd2) && (sel_id != 5'd0);
    assign complete  = wr_hs && (wr_addr == 2'd2) && (axi_wdata[4:0] == claimed_id_q)
                       && (state_q == ST_SERVICE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            irq_s_q <= '0;
        end else begin
            sync1_q <= irq_i;
            irq_s_q <= sync1_q;
        end
    end

`ifdef EIRQ_EDGE_EN
    logic [W-1:0] mode_q, mode_d;
    logic [W-1:0] edge_pend_q, edge_pend_d, irq_s_prev_q;
    logic [W-1:0] edge_set, edge_clr;

    always_comb begin
        mode_d = mode_q;
        if (wr_hs && wr_addr == 2'd3) mode_d = (mode_q & ~wmask) | (wdata_w & wmask);
        edge_set = irq_s_q & ~irq_s_prev_q & mode_q;
        edge_clr = '0;
        if (wr_hs && wr_addr == 2'd1) edge_clr = wdata_w & wmask;
        if (claim_hit) edge_clr = edge_clr | (W'(1) << (sel_id - 5'd1));
        // A new edge arriving alongside a clear must not be lost.
        edge_pend_d = mode_q & ((edge_pend_q & ~edge_clr) | edge_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= '0;
            edge_pend_q  <= '0;
            irq_s_prev_q <= '0;
        end else begin
            mode_q       <= mode_d;
            edge_pend_q  <= edge_pend_d;
            irq_s_prev_q <= irq_s_q;
        end
    end

    assign pending = (mode_q & edge_pend_q) | (~mode_q & irq_s_q);
    assign mode_rd = 32'(mode_q);
`else
    assign pending = irq_s_q;
    assign mode_rd = 32'd0;
`endif

    always_comb begin
        case (axi_araddr[3:2])
            2'd0:    rd_val = 32'(enable_q);
            2'd1:    rd_val = 32'(pending);
            2'd2:    rd_val = 32'(sel_id);
            default: rd_val = mode_rd;
        endcase
    end

    always_comb begin
        enable_d = enable_q;
        if (wr_hs && wr_addr == 2'd0) enable_d = (enable_q & ~wmask) | (wdata_w & wmask);
        claimed_id_d = claimed_id_q;
        if (complete)  claimed_id_d = 5'd0;
        if (claim_hit) claimed_id_d = sel_id;
        aw_rdy_d  = ~aw_rdy_q & axi_awvalid & axi_wvalid & ~bvalid_q;
        bvalid_d  = wr_hs | (bvalid_q & ~axi_bready);
        rvalid_d  = ar_hs | (rvalid_q & ~axi_rready);
        arready_d = ~rvalid_d;
        rdata_d   = ar_hs ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q     <= '0;
            pend_q       <= '0;
            claimed_id_q <= 5'd0;
            aw_rdy_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            enable_q     <= enable_d;
            pend_q       <= pending;
            claimed_id_q <= claimed_id_d;
            aw_rdy_q     <= aw_rdy_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    // No nesting: SERVICE only leaves on a matching completion write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            trap_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|fsm_active) begin
                        state_q      <= ST_REQ;
                        trap_valid_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (trap_valid_q && trap_ready_i) begin
                        state_q      <= ST_SERVICE;
                        trap_valid_q <= 1'b0;
                    end else if (!(|fsm_active)) begin
                        state_q      <= ST_IDLE;
                        trap_valid_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    trap_valid_q <= 1'b0;
                    if (complete) state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    trap_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign trap_valid_o = trap_valid_q;
    assign axi_awready  = aw_rdy_q;
    assign axi_wready   = aw_rdy_q;
    assign axi_bvalid   = bvalid_q;
    assign axi_bresp    = 2'b00;
    assign axi_arready  = arready_q;
    assign axi_rvalid   = rvalid_q;
    assign axi_rdata    = rdata_q;
    assign axi_rresp    = 2'b00;

    logic unused_ok;
    assign unused_ok = ^{axi_awaddr, axi_araddr, axi_wdata, wmask32};
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: vector table for arbitration plus hand sequences for timing corners.
module tb_ext_irq_ctrl;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_i;
    logic          trap_valid_o, trap_ready_i;
    logic [31:0]   axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [3:0]    axi_wstrb;
    logic [1:0]    axi_bresp, axi_rresp;
    logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   exp_q[$];

    always #5 clk = ~clk;

    ext_irq_ctrl #(.IRQ_NUM(N)) dut (
        .clk(clk), .rst_n(rst_n), .irq_i(irq_i),
        .trap_valid_o(trap_valid_o), .trap_ready_i(trap_ready_i),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    typedef struct {
        logic [N-1:0] irq;
        logic [N-1:0] en;
        logic [4:0]   exp_id;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int cnt;
        axi_awaddr  = {28'd0, addr};
        axi_wdata   = data;
        axi_wstrb   = strb;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        cnt = 0;
        while (!axi_awready && cnt < 20) begin
            tick(1);
            cnt++;
        end
        if (!axi_awready) check("awready_wait", 32'(axi_awready), 32'd1);
        tick(1);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        cnt = 0;
        while (!axi_bvalid && cnt < 20) begin
            tick(1);
            cnt++;
        end
        if (!axi_bvalid) check("bvalid_wait", 32'(axi_bvalid), 32'd1);
        check("bresp", 32'(axi_bresp), 32'd0);
        axi_bready = 1'b1;
        tick(1);
        axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int cnt;
        axi_araddr  = {28'd0, addr};
        axi_arvalid = 1'b1;
        cnt = 0;
        while (!axi_arready && cnt < 20) begin
            tick(1);
            cnt++;
        end
        if (!axi_arready) check("arready_wait", 32'(axi_arready), 32'd1);
        tick(1);
        axi_arvalid = 1'b0;
        cnt = 0;
        while (!axi_rvalid && cnt < 20) begin
            tick(1);
            cnt++;
        end
        if (!axi_rvalid) check("rvalid_wait", 32'(axi_rvalid), 32'd1);
        data = axi_rdata;
        check("rresp", 32'(axi_rresp), 32'd0);
        axi_rready = 1'b1;
        tick(1);
        axi_rready = 1'b0;
    endtask

    task automatic read_chk(input logic [3:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] d;
        exp_q.push_back(exp);
        axi_read(addr, d);
        check(name, d, exp_q.pop_front());
    endtask

    task automatic ack_trap();
        trap_ready_i = 1'b1;
        tick(1);
        trap_ready_i = 1'b0;
        check("trap_after_ack", 32'(trap_valid_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] mode_exp;
        int          cnt;

        vecs[0] = '{irq: 8'h04, en: 8'h05, exp_id: 5'd3};
        vecs[1] = '{irq: 8'h06, en: 8'hFF, exp_id: 5'd2};
        vecs[2] = '{irq: 8'h80, en: 8'hFF, exp_id: 5'd8};
        vecs[3] = '{irq: 8'h80, en: 8'h7F, exp_id: 5'd0};
        vecs[4] = '{irq: 8'h00, en: 8'hFF, exp_id: 5'd0};
        vecs[5] = '{irq: 8'hF0, en: 8'hA0, exp_id: 5'd6};
        vecs[6] = '{irq: 8'h01, en: 8'h01, exp_id: 5'd1};
        vecs[7] = '{irq: 8'hFF, en: 8'h00, exp_id: 5'd0};

        rst_n = 1'b0; irq_i = '0; trap_ready_i = 1'b0;
        axi_awaddr = '0; axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
        axi_bready = 1'b0; axi_araddr = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
        tick(2);
        check("rst_trap_valid", 32'(trap_valid_o), 32'd0);
        check("rst_awready", 32'(axi_awready), 32'd0);
        check("rst_arready", 32'(axi_arready), 32'd0);
        check("rst_bvalid", 32'(axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("rst_rdata", axi_rdata, 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("arready_after_rst", 32'(axi_arready), 32'd1);

        // Level latency: irq driven before edge k, trap_valid_o rises after edge k+3.
        axi_write(4'h0, 32'h05, 4'hF);
        irq_i = 8'h04;
        tick(3);
        check("lat_k2", 32'(trap_valid_o), 32'd0);
        tick(1);
        check("lat_k3", 32'(trap_valid_o), 32'd1);
        ack_trap();
        read_chk(4'h8, 32'd3, "claim_id3");
        axi_write(4'h8, 32'd5, 4'hF);
        tick(4);
        check("wrong_complete_stays", 32'(trap_valid_o), 32'd0);
        axi_write(4'h8, 32'd3, 4'hF);
        tick(3);
        check("complete_rereq", 32'(trap_valid_o), 32'd1);
        axi_write(4'h0, 32'h00, 4'hF);
        check("withdraw_on_disable", 32'(trap_valid_o), 32'd0);
        tick(2);
        check("withdraw_stays_idle", 32'(trap_valid_o), 32'd0);
        irq_i = '0;
        tick(4);

        // Level still high after completion re-raises the same ID.
        axi_write(4'h0, 32'hFF, 4'hF);
        irq_i = 8'h06;
        tick(5);
        check("l2_trap", 32'(trap_valid_o), 32'd1);
        ack_trap();
        read_chk(4'h8, 32'd2, "l2_claim1");
        axi_write(4'h8, 32'd2, 4'hF);
        tick(3);
        check("l2_rereq", 32'(trap_valid_o), 32'd1);
        ack_trap();
        read_chk(4'h8, 32'd2, "l2_claim2");
        irq_i = '0;
        axi_write(4'h8, 32'd2, 4'hF);
        tick(4);
        check("l2_idle", 32'(trap_valid_o), 32'd0);

        for (int v = 0; v < 8; v++) begin
            axi_write(4'h0, 32'(vecs[v].en), 4'hF);
            irq_i = vecs[v].irq;
            tick(5);
            check($sformatf("vec%0d_trap", v), 32'(trap_valid_o), 32'(vecs[v].exp_id != 5'd0));
            if (vecs[v].exp_id != 5'd0) ack_trap();
            read_chk(4'h8, 32'(vecs[v].exp_id), $sformatf("vec%0d_claim", v));
            irq_i = '0;
            if (vecs[v].exp_id != 5'd0) axi_write(4'h8, 32'(vecs[v].exp_id), 4'hF);
            tick(5);
            check($sformatf("vec%0d_idle", v), 32'(trap_valid_o), 32'd0);
        end

        axi_write(4'h0, 32'hFFFF_FFFF, 4'h0);
        read_chk(4'h0, 32'h00, "en_strb_none");
        axi_write(4'h0, 32'hFFFF_FFFF, 4'hF);
        read_chk(4'h0, 32'hFF, "en_upper_bits_zero");
        axi_write(4'h0, 32'h0000_0000, 4'h2);
        read_chk(4'h0, 32'hFF, "en_strb_lane1");
        axi_write(4'h0, 32'h0000_0000, 4'h1);
        read_chk(4'h0, 32'h00, "en_clear");

        irq_i = 8'h5A;
        tick(3);
        read_chk(4'h4, 32'h5A, "pending_level");
        axi_write(4'h4, 32'hFF, 4'hF);
        read_chk(4'h4, 32'h5A, "pending_w1c_level");
        irq_i = '0;
        tick(3);

`ifdef EIRQ_EDGE_EN
        mode_exp = 32'hFF;
`else
        mode_exp = 32'h00;
`endif
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        read_chk(4'hC, mode_exp, "mode_readback");
        axi_write(4'hC, 32'h0, 4'hF);

`ifdef EIRQ_EDGE_EN
        axi_write(4'hC, 32'h01, 4'hF);
        axi_write(4'h0, 32'h01, 4'hF);
        irq_i = 8'h01;
        tick(3);
        irq_i = '0;
        tick(4);
        read_chk(4'h4, 32'h01, "edge_pending");
        read_chk(4'h8, 32'd1, "edge_claim");
        read_chk(4'h4, 32'h00, "edge_claim_clears");
        irq_i = 8'h01;
        tick(3);
        irq_i = '0;
        tick(4);
        read_chk(4'h4, 32'h01, "edge_pending2");
        // New edge lands on the same clock as the claim handshake.
        irq_i = 8'h01;
        tick(2);
        axi_araddr  = 32'h8;
        axi_arvalid = 1'b1;
        tick(1);
        axi_arvalid = 1'b0;
        check("edge_claim_same_cycle", axi_rdata, 32'd1);
        axi_rready = 1'b1;
        tick(1);
        axi_rready = 1'b0;
        irq_i = '0;
        read_chk(4'h4, 32'h01, "edge_set_wins");
        axi_write(4'h4, 32'h01, 4'hF);
        read_chk(4'h4, 32'h00, "edge_w1c");
        axi_write(4'h0, 32'h00, 4'hF);
        axi_write(4'hC, 32'h00, 4'hF);
        tick(4);
`endif

        // Reset while a write response is waiting on bready.
        axi_awaddr  = 32'h0;
        axi_wdata   = 32'hFF;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_bready  = 1'b0;
        cnt = 0;
        while (!axi_bvalid && cnt < 20) begin
            tick(1);
            cnt++;
        end
        check("bvalid_before_rst", 32'(axi_bvalid), 32'd1);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        rst_n = 1'b0;
        tick(1);
        check("bvalid_in_rst", 32'(axi_bvalid), 32'd0);
        check("awready_in_rst", 32'(axi_awready), 32'd0);
        rst_n = 1'b1;
        tick(3);
        check("bvalid_after_rst", 32'(axi_bvalid), 32'd0);
        read_chk(4'h0, 32'h00, "en_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ext_irq_ctrl.md
EXT_IRQ_CTRL -- requirements
Module: ext_irq_ctrl

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 8, legal 1..31: number of external interrupt channels; channel ID = index+1.
REQ-002 SHALL have the following ports:
  clk  in  1  system clock
  rst_n  in  1  reset, asynchronous, active-low
  irq_i  in  IRQ_NUM  asynchronous interrupt lines, active-high
  trap_valid_o  out  1  interrupt request to core (core_ex_trap_valid)
  trap_ready_i  in  1  core accepted interrupt (core_ex_trap_ready)
  axi_awaddr/awvalid/awready  in/in/out  32/1/1  AXI4-Lite write address
  axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data
  axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
  axi_araddr/arvalid/arready  in/in/out  32/1/1  read address
  axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data
REQ-003 SHALL decode only awaddr/araddr[3:2]; awprot/arprot SHALL NOT exist.

Function
REQ-004 Each irq_i bit SHALL pass a 2-flop synchronizer (irq_s) before use.
REQ-005 Register map: 0x0 ENABLE RW; 0x4 PENDING RO (W1C for edge channels); 0x8 CLAIM/COMPLETE; 0xC MODE RW (1=rising edge, 0=level). Bits above IRQ_NUM-1 read 0, writes ignored.
REQ-006 Level channel: pending = irq_s (no storage). Edge channel: pending flop set on irq_s 0->1, cleared by W1C or by claim.
REQ-007 Set SHALL win over clear when both occur on one channel in the same cycle.
REQ-008 Active set = pending & ENABLE; selected ID = lowest active index +1, 0 if none.
REQ-009 FSM IDLE/REQ/SERVICE, trap_valid_o registered, =1 only in REQ.
REQ-010 IDLE->REQ when active set nonzero; REQ->SERVICE on trap_valid_o & trap_ready_i; REQ->IDLE if active set becomes zero (request withdrawn, permitted).
REQ-011 CLAIM read returns selected ID and latches it as claimed_id; in edge mode clears that channel's pending; returns 0 and no side effect if none.
REQ-012 CLAIM write of wdata[4:0]==claimed_id in SERVICE SHALL move FSM to IDLE and clear claimed_id; any other value/state SHALL be ignored.
REQ-013 Nesting SHALL NOT occur: no new trap_valid_o while in SERVICE; ENABLE changes in SERVICE have no effect on state.
REQ-014 Latency: level irq_i high before edge k -> trap_valid_o high after edge k+3; edge mode -> after edge k+4.
REQ-015 Write channel: awready=wready=1 for one cycle when awvalid & wvalid & !bvalid; bvalid next cycle, held until bready; wstrb byte lanes honoured for ENABLE/MODE.
REQ-016 Read channel: arready=1 when !rvalid; rvalid next cycle, rdata stable until rvalid & rready; claim side effect occurs at ar handshake.
REQ-017 bresp/rresp SHALL always be 2'b00; unmapped reads return 0.

Reset
REQ-018 On rst_n low: ENABLE=0, MODE=0, pending=0, sync flops=0, claimed_id=0, FSM=IDLE, trap_valid_o=0, awready=wready=arready=0, bvalid=rvalid=0, rdata=0.
REQ-019 Reset mid-transaction SHALL abort it; no response issued after release.

Configuration
REQ-020 Macro EIRQ_EDGE_EN: defined -> MODE register and edge pending flops present per REQ-005/006.
REQ-021 EIRQ_EDGE_EN undefined -> all channels level, 0xC reads 0, W1C to PENDING ignored, no edge flops built.

Verification
REQ-022 IRQ_NUM=8, ENABLE=0x05, irq_i=0x04 -> trap_valid_o=1 after 3 edges; ready -> CLAIM read returns 3.
REQ-023 irq_i=0x06, ENABLE=0xFF -> CLAIM returns 2; write 2 -> IDLE, then new REQ, CLAIM returns 2 again (level still high).
REQ-024 EIRQ_EDGE_EN, MODE=0x01, pulse irq_i[0] 3 cycles -> PENDING=0x01; claim -> PENDING=0x00; second edge same cycle as claim -> PENDING stays 0x01.
REQ-025 In SERVICE with claimed_id=3, write CLAIM=5 -> stays SERVICE, trap_valid_o=0; write 3 -> IDLE.
REQ-026 REQ state, clear ENABLE -> trap_valid_o drops next cycle, FSM IDLE; rst_n low mid write with bready=0 -> bvalid=0 after release.
